// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide single-cycle memory port.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
`timescale 1ns/1ps
module lsu_mem_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [2:0] {
      IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        misaligned;
   logic [31:0] merged;
   logic [31:0] extended;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign misaligned = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);

   // Store data lands in the addressed lane of the word just read back.
   always_comb begin
      merged = mem_rdata;
      if (size_q == 2'b00) begin
         merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_comb begin
      byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
      half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   extended = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
         2'b01:   extended = {{16{half_sel[15] & ~uns_q}}, half_sel};
         default: extended = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d        = req_we;
               size_d      = req_size;
               uns_d       = req_unsigned;
               lane_d      = req_addr[1:0];
               wdata_d     = req_wdata;
               mem_addr_d  = {req_addr[31:2], 2'b00};
               mem_wdata_d = req_wdata;
               rdata_d     = '0;
               err_d       = 1'b0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (req_we && req_size == 2'b10) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            cnt_d   = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_ready) begin
               if (we_q) begin
                  mem_wdata_d = merged;
                  state_d     = WR;
               end else begin
                  rdata_d = extended;
                  state_d = RESP;
               end
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WR: begin
            cnt_d   = '0;
            state_d = WR_WAIT;
         end
         WR_WAIT: begin
            if (mem_ready) begin
               state_d = RESP;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // Handshake: a request is taken on a clk edge where req_valid and req_ready are both high.
   assign req_ready  = (state_q == IDLE) && !rst;
   assign mem_read   = (state_q == RD);
   assign mem_write  = (state_q == WR);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid & err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: memory stub, per-scenario tasks, response scoreboard.
`timescale 1ns/1ps
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic        stall = 1'b0;
   logic [31:0] smem    [0:255];
   logic [31:0] ref_mem [0:255];
   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   lsu_mem_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Compliant responder: ready one cycle after each pulse unless stalled.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= (mem_read | mem_write) & ~stall;
         if (mem_read) mem_rdata <= smem[mem_addr[9:2]];
         if (mem_write) smem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lane);
      logic [31:0] sh;
      sh = w >> (lane * 8);
      if (size == 2'b00) return uns ? (sh & 32'hFF) : (sh[7] ? (sh | 32'hFFFFFF00) : (sh & 32'hFF));
      if (size == 2'b01) return uns ? (sh & 32'hFFFF) : (sh[15] ? (sh | 32'hFFFF0000) : (sh & 32'hFFFF));
      return w;
   endfunction

   function automatic logic [31:0] st_model(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] lane, input logic [31:0] d);
      logic [31:0] mask;
      if (size == 2'b10) return d;
      mask = (size == 2'b00) ? 32'hFF : 32'hFFFF;
      return (w & ~(mask << (lane * 8))) | ((d & mask) << (lane * 8));
   endfunction

   task automatic test_reset();
      #2;
      n_checks++;
      if ({req_ready, mem_read, mem_write, resp_valid, resp_err} !== 5'b0) $display("FAIL reset_ctrl: got %b required 00000", {req_ready, mem_read, mem_write, resp_valid, resp_err});
      else n_pass++;
      n_checks++;
      if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) $display("FAIL reset_data: got %h/%h/%h required 0", resp_rdata, mem_addr, mem_wdata);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", req_ready);
      else n_pass++;
   endtask

   // One request; checks pulse timing, write data, address and the scoreboarded response.
   task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_rd, input int exp_wr, input int exp_lat,
                         input logic [31:0] exp_wdata);
      int rd_cyc, wr_cyc, nrd, nwr, nboth, lat;
      logic [31:0] wd_seen;
      logic [32:0] exp;
      rd_cyc = 0; wr_cyc = 0; nrd = 0; nwr = 0; nboth = 0; lat = 0; wd_seen = '0;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s_ready_before: got %b required 1", name, req_ready);
      else n_pass++;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      exp_q.push_back({exp_err, exp_rdata});
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mem_read && mem_write) nboth++;
         if (mem_read) begin nrd++; if (rd_cyc == 0) rd_cyc = k; end
         if (mem_write) begin nwr++; if (wr_cyc == 0) wr_cyc = k; wd_seen = mem_wdata; end
         if (resp_valid) begin
            lat = k;
            exp = exp_q.pop_front();
            n_checks++;
            if ({resp_err, resp_rdata} !== exp) $display("FAIL %s_resp: got err=%b data=%h required err=%b data=%h", name, resp_err, resp_rdata, exp[32], exp[31:0]);
            else n_pass++;
            break;
         end
      end
      if (lat == 0) begin
         void'(exp_q.pop_front());
      end
      n_checks++;
      if (lat != exp_lat) $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
      else n_pass++;
      n_checks++;
      if (rd_cyc != exp_rd || nrd != ((exp_rd != 0) ? 1 : 0)) $display("FAIL %s_read: got cycle %0d count %0d required cycle %0d", name, rd_cyc, nrd, exp_rd);
      else n_pass++;
      n_checks++;
      if (wr_cyc != exp_wr || nwr != ((exp_wr != 0) ? 1 : 0)) $display("FAIL %s_write: got cycle %0d count %0d required cycle %0d", name, wr_cyc, nwr, exp_wr);
      else n_pass++;
      n_checks++;
      if (nboth != 0) $display("FAIL %s_rw_overlap: got %0d cycles required 0", name, nboth);
      else n_pass++;
      if (exp_wr != 0) begin
         n_checks++;
         if (wd_seen !== exp_wdata) $display("FAIL %s_wdata: got %h required %h", name, wd_seen, exp_wdata);
         else n_pass++;
      end
      n_checks++;
      if (mem_addr !== {addr[31:2], 2'b00}) $display("FAIL %s_addr: got %h required %h", name, mem_addr, {addr[31:2], 2'b00});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) $display("FAIL %s_after: got ready=%b valid=%b err=%b data=%h required 1/0/0/0", name, req_ready, resp_valid, resp_err, resp_rdata);
      else n_pass++;
   endtask

   task automatic test_loads();
      do_req("lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 1, 0, 3, 32'h0);
      do_req("lb",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hFFFFFF88, 1'b0, 1, 0, 3, 32'h0);
      do_req("lbu", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000AA, 1'b0, 1, 0, 3, 32'h0);
      do_req("lh",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 1, 0, 3, 32'h0);
      do_req("lhu", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h0000AABB, 1'b0, 1, 0, 3, 32'h0);
   endtask

   task automatic test_stores();
      do_req("sb",  1'b1, 2'b00, 1'b0, 32'h101, 32'h12345655, 32'h0, 1'b0, 1, 3, 5, 32'h889955BB);
      do_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h889955BB, 1'b0, 1, 0, 3, 32'h0);
      do_req("sw",  1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1, 3, 32'hDEADBEEF);
   endtask

   task automatic test_misaligned();
      do_req("lh_mis",  1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 0, 0, 1, 32'h0);
      do_req("sw_mis",  1'b1, 2'b10, 1'b0, 32'h102, 32'h11111111, 32'h0, 1'b1, 0, 0, 1, 32'h0);
      do_req("size11",  1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 0, 0, 1, 32'h0);
   endtask

   task automatic test_timeout();
      stall = 1'b1;
      do_req("lw_tmo", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 18, 32'h0);
      do_req("sb_tmo", 1'b1, 2'b00, 1'b0, 32'h101, 32'h77, 32'h0, 1'b1, 1, 0, 18, 32'h0);
      stall = 1'b0;
      do_req("lw_post_tmo", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 3, 32'h0);
   endtask

   task automatic test_mid_reset();
      int bad;
      bad = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h100; req_wdata = 32'h00007777;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({req_ready, mem_read, mem_write, resp_valid, mem_addr, mem_wdata} !== 68'h0) $display("FAIL midrst_clear: got ready=%b rd=%b wr=%b valid=%b addr=%h wdata=%h required all 0", req_ready, mem_read, mem_write, resp_valid, mem_addr, mem_wdata);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (mem_write || resp_valid) bad++;
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", req_ready);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (mem_write || resp_valid) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL midrst_no_activity: got %0d cycles with write/resp required 0", bad);
      else n_pass++;
      do_req("lw_post_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, 3, 32'h0);
   endtask

   task automatic test_back_to_back();
      logic        we, uns;
      logic [1:0]  size, lane;
      logic [31:0] addr, wdata, old, nw, exp_d;
      for (int i = 0; i < 10; i++) begin
         we = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 2));
         uns = 1'($urandom_range(0, 1));
         lane = 2'($urandom_range(0, 3));
         if (size == 2'b01) lane[0] = 1'b0;
         if (size == 2'b10) lane = 2'b00;
         addr = 32'h200 + 32'($urandom_range(0, 3)) * 4 + {30'h0, lane};
         wdata = $urandom;
         old = ref_mem[addr[9:2]];
         if (!we) begin
            exp_d = ld_model(old, size, uns, lane);
            do_req("rand_ld", we, size, uns, addr, wdata, exp_d, 1'b0, 1, 0, 3, 32'h0);
         end else begin
            nw = st_model(old, size, lane, wdata);
            if (size == 2'b10) do_req("rand_sw", we, size, uns, addr, wdata, 32'h0, 1'b0, 0, 1, 3, nw);
            else do_req("rand_rmw", we, size, uns, addr, wdata, 32'h0, 1'b0, 1, 3, 5, nw);
            ref_mem[addr[9:2]] = nw;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         smem[i] = (i * 32'h01030507) ^ 32'hA5C3_0F96;
         ref_mem[i] = (i * 32'h01030507) ^ 32'hA5C3_0F96;
      end
      smem[64] = 32'h8899AABB;
      ref_mem[64] = 32'h8899AABB;
      test_reset();
      test_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Initiator for the core's word-wide single-cycle memory port. It accepts byte, halfword and word load/store requests from the pipeline's load/store stage and converts them into one-cycle read/write pulses on the memory port, then waits for `mem_ready`. Sub-word stores are performed as read-modify-write, because the memory port only writes whole words. Load data is lane-extracted and sign- or zero-extended. Misaligned accesses and responder timeouts are reported as errors.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: number of `*_WAIT` cycles without `mem_ready` before the access is aborted with an error; range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both `req_valid` and `req_ready` are high at a clk edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal size or timeout.
- mem_read  out  1  read pulse to the memory port.
- mem_write  out  1  write pulse to the memory port.
- mem_addr  out  32  word-aligned address: `{req_addr[31:2], 2'b00}`.
- mem_wdata  out  32  full word written.
- mem_rdata  in  32  read data; valid in the cycle `mem_ready` is high.
- mem_ready  in  1  completion; arrives one cycle after a pulse from a compliant responder.

## Operation
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- `req_ready` = (state == IDLE). It is 0 while `rst` is high.
- On accept, latch `req_we`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata`. Later changes on the `req_*` inputs are ignored.
- Alignment check on accept. An access is an error if any of these hold:
  - size is 11,
  - size is 01 and `addr[0]` = 1,
  - size is 10 and `addr[1:0]` ≠ 0.
  On error go to RESP with `resp_err` = 1. No memory access is made.
- Transitions out of IDLE on accept:
  - load → RD
  - word store → WR
  - byte/halfword store → RD (read-modify-write)
- RD drives `mem_read` = 1 for exactly one cycle, then goes to RD_WAIT.
- WR drives `mem_write` = 1 for exactly one cycle with the merged or full `mem_wdata`, then goes to WR_WAIT.
- RD_WAIT:
  - On `mem_ready`, capture `mem_rdata`.
  - For a load, go to RESP.
  - For a sub-word store, merge into the captured word and go to WR. Merge: lane = `addr[1:0]`, little-endian; byte replaces bits [8*lane+7 : 8*lane]; halfword replaces bits [16*addr[1]+15 : 16*addr[1]].
- WR_WAIT goes to RESP on `mem_ready`.
- Timeout: an 8-bit counter clears on entry to each `*_WAIT` state and increments every cycle there without `mem_ready`. When it reaches TIMEOUT_CYCLES, go to RESP with `resp_err` = 1 and `resp_rdata` = 0. A timed-out RMW read never issues its write.
- `mem_ready` is ignored outside the `*_WAIT` states.
- Load extraction: select the addressed byte or halfword. Extend with bit 7 or bit 15 (sign), or with zeros if `req_unsigned` = 1. Word loads pass through unchanged.
- RESP asserts `resp_valid` for one cycle, then returns to IDLE. `resp_rdata` and `resp_err` are valid only while `resp_valid` = 1 and are 0 otherwise.
- `mem_addr` and `mem_wdata` are held from accept until the next accept. They are 0 after reset.

## Timing
Reset values:
- State = IDLE.
- `mem_read`, `mem_write`, `resp_valid`, `resp_err` = 0.
- `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- `req_ready` = 0 while `rst` is high, 1 in the first cycle after `rst` is released.

Latency, with the accept edge at the end of cycle A:
- Load or word store: pulse in A+1, `mem_ready` in A+2, `resp_valid` in A+3, `req_ready` in A+4.
- Sub-word store: read in A+1, ready in A+2, write in A+3, ready in A+4, `resp_valid` in A+5.
- Misaligned access: `resp_valid` with `resp_err` in A+1.
- Stalled responder: the error response comes TIMEOUT_CYCLES cycles after the wait begins, plus one.

Rules:
- `mem_read` and `mem_write` are never high in the same cycle.
- At most one memory pulse is outstanding at a time.
- Throughput is at most one request per 4 cycles.
- Reset mid-operation: all outputs clear asynchronously. No pending write is issued and no response is produced.

## Test plan
Preload the word at 0x100 with 0x8899AABB.
- LW 0x100 → `mem_read` high only in A+1 with `mem_addr` = 0x100; `resp_valid` in A+3 with `resp_rdata` = 0x8899AABB and `resp_err` = 0.
- LB 0x103 → 0xFFFFFF88. LBU 0x101 → 0x000000AA. LH 0x102 → 0xFFFF8899. LHU 0x100 → 0x0000AABB.
- SB 0x101 with `req_wdata` = 0x12345655 → read in A+1, write in A+3 with `mem_wdata` = 0x889955BB, `resp_valid` in A+5. SW 0x100 with 0xDEADBEEF → write in A+1 with `mem_wdata` = 0xDEADBEEF, no read.
- LH 0x101, SW 0x102, and size 11 → `resp_err` = 1 in A+1; `mem_read` and `mem_write` stay 0 throughout.
- Stub never asserts `mem_ready`, TIMEOUT_CYCLES = 16, on LW and on SB → error response after 16 wait cycles with `resp_rdata` = 0; the SB issues no write. The next request is then accepted normally.
- Assert `rst` during RD_WAIT of SH 0x100 → no `mem_write` and no `resp_valid`; `req_ready` = 1 after release; a following LW completes correctly.
